// File: rtl/aes_cipher_seq_pkg.sv
// aes_cipher_seq_pkg: shared AES-128 types, S-box, sequencer states and byte helpers
package aes_cipher_seq_pkg;
  typedef logic [127:0] t_opaque_AESState;
  typedef logic [127:0] t_opaque_AESKey;
  typedef logic [31:0] t_opaque_AESWord;
  typedef enum logic [1:0] {IDLE, RUN, DONE} t_aes_seq_state;
  localparam int AES128_ROUNDS = 10;
  // S-box entry b sits at bits {~b, 3'b111} downto 8 bits, entry 0 in the MSBs
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction
  function automatic t_opaque_AESWord sub_word(input t_opaque_AESWord w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_cipher_seq_key_step.sv
// aes_key_step: one AES-128 key-expansion step, current round key to next
module aes_key_step import aes_cipher_seq_pkg::*; (
  input  t_opaque_AESKey i_key,
  input  logic [7:0]     i_rcon,
  output t_opaque_AESKey o_key
);
  t_opaque_AESWord w_t, w_w0, w_w1, w_w2, w_w3;
  assign w_t  = sub_word({i_key[23:0], i_key[31:24]}) ^ {i_rcon, 24'h0};
  assign w_w0 = i_key[127:96] ^ w_t;
  assign w_w1 = i_key[95:64] ^ w_w0;
  assign w_w2 = i_key[63:32] ^ w_w1;
  assign w_w3 = i_key[31:0] ^ w_w2;
  assign o_key = {w_w0, w_w1, w_w2, w_w3};
endmodule

// File: rtl/aes_cipher_seq_round.sv
// aes_cipher_seq_round: AES round primitives (subBytes, shiftRows, mixColumns, addRoundKey)
module aes_sub_bytes import aes_cipher_seq_pkg::*; (
  input  t_opaque_AESState i_state,
  output t_opaque_AESState o_state
);
  for (genvar k = 0; k < 16; k++) begin : g_k
    assign o_state[127-8*k -: 8] = sbox(i_state[127-8*k -: 8]);
  end
endmodule

module aes_shift_rows import aes_cipher_seq_pkg::*; (
  input  t_opaque_AESState i_state,
  output t_opaque_AESState o_state
);
  // byte state[c][r] lives at index 4c+r; row r rotates left by r columns
  for (genvar c = 0; c < 4; c++) begin : g_c
    for (genvar r = 0; r < 4; r++) begin : g_r
      assign o_state[127-8*(4*c+r) -: 8] = i_state[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end
endmodule

module aes_mix_columns import aes_cipher_seq_pkg::*; (
  input  t_opaque_AESState i_state,
  output t_opaque_AESState o_state
);
  for (genvar c = 0; c < 4; c++) begin : g_c
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign {w_a0, w_a1, w_a2, w_a3} = i_state[127-32*c -: 32];
    assign o_state[127-32*c -: 32] = {
      xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
      w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3,
      w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3,
      xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3)
    };
  end
endmodule

module aes_add_round_key import aes_cipher_seq_pkg::*; (
  input  t_opaque_AESState i_state,
  input  t_opaque_AESKey   i_key,
  output t_opaque_AESState o_state
);
  assign o_state = i_state ^ i_key;
endmodule

// File: rtl/aes_cipher_seq.sv
// aes_cipher_seq: iterative AES-128 encryptor, one round per clock over a shared datapath
module aes_cipher_seq import aes_cipher_seq_pkg::*; #(
  parameter int ROUNDS = AES128_ROUNDS,
  localparam int RW = $clog2(ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  t_opaque_AESState in_data,
  input  t_opaque_AESKey   in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output t_opaque_AESState out_data,
  output logic             busy,
  output logic [RW-1:0]    round
);
  localparam logic [RW-1:0] LAST = RW'(ROUNDS);
  t_aes_seq_state r_fsm, w_fsm_nxt;
  t_opaque_AESState r_state, w_sb, w_sr, w_mc, w_pre, w_ark, w_ark0;
  t_opaque_AESKey r_key, w_nk;
  logic [7:0] r_rcon;
  logic [RW-1:0] r_round;
  aes_sub_bytes u_sb (.i_state(r_state), .o_state(w_sb));
  aes_shift_rows u_sr (.i_state(w_sb), .o_state(w_sr));
  aes_mix_columns u_mc (.i_state(w_sr), .o_state(w_mc));
  aes_key_step u_ks (.i_key(r_key), .i_rcon(r_rcon), .o_key(w_nk));
  aes_add_round_key u_ark (.i_state(w_pre), .i_key(w_nk), .o_state(w_ark));
  aes_add_round_key u_ark0 (.i_state(in_data), .i_key(in_key), .o_state(w_ark0));
  // the final round skips mixColumns
  assign w_pre = (r_round == LAST) ? w_sr : w_mc;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_fsm <= IDLE;
    else r_fsm <= w_fsm_nxt;
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_fsm_nxt = (r_fsm == IDLE && in_valid) ? RUN :
                (r_fsm == RUN && r_round == LAST) ? DONE :
                (r_fsm == DONE && out_ready) ? IDLE : r_fsm;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= '0;
      r_key <= '0;
      r_rcon <= 8'h01;
      r_round <= '0;
    end else if (r_fsm == IDLE && in_valid) begin
      r_state <= w_ark0;
      r_key <= in_key;
      r_rcon <= 8'h01;
      r_round <= RW'(1);
    end else if (r_fsm == RUN) begin
      r_state <= w_ark;
      r_key <= w_nk;
      r_rcon <= xtime(r_rcon);
      if (r_round != LAST) r_round <= r_round + RW'(1);
    end
  assign in_ready = (r_fsm == IDLE);
  assign busy = (r_fsm == RUN);
  assign out_valid = (r_fsm == DONE);
  assign out_data = r_state;
  assign round = r_round;
endmodule

// File: tb/tb_aes_cipher_seq.sv
// tb_aes_cipher_seq: scoreboard bench for the iterative AES-128 sequencer
module tb_aes_cipher_seq;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, busy;
  logic [127:0] in_data = '0, in_key = '0, out_data;
  logic [3:0] round;
  int n_chk = 0, n_pass = 0, cyc = 0, t_acc = 0, t_prev = 0, n;
  logic [127:0] sb[$];
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  aes_cipher_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .round(round)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] ct);
    int k = 0;
    in_valid = 1;
    in_data = pt;
    in_key = key;
    while (!in_ready && k < 100) begin
      step();
      k++;
    end
    chk("accept_wait", 128'(in_ready), 128'(1));
    sb.push_back(ct);
    step();
    t_prev = t_acc;
    t_acc = cyc;
  endtask
  task automatic wait_out(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 50) begin
      step();
      cnt++;
    end
    chk("out_wait", 128'(out_valid), 128'(1));
  endtask
  always @(negedge clk)
    if (rst && out_valid && out_ready) begin
      chk("sb_depth", 128'(sb.size()), 128'(1));
      if (sb.size() > 0) chk("ciphertext", out_data, sb.pop_front());
    end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) step();
    rst = 1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_round", 128'(round), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    out_ready = 1;
    send(PB, KB, CB);
    in_valid = 0;
    chk("run_busy", 128'(busy), 128'(1));
    chk("run_in_ready", 128'(in_ready), 128'(0));
    wait_out(n);
    chk("latency_b", 128'(n), 128'(10));
    step();
    chk("idle_after_hs", 128'(in_ready), 128'(1));
    chk("valid_drop_hs", 128'(out_valid), 128'(0));
    send(PC, KC, CC);
    in_valid = 0;
    for (int i = 1; i <= 10; i++) begin
      chk("round_step", 128'(round), 128'(i));
      step();
    end
    chk("c1_valid", 128'(out_valid), 128'(1));
    step();
    out_ready = 0;
    send(PB, KB, CB);
    in_valid = 0;
    wait_out(n);
    repeat (20) begin
      chk("bp_data", out_data, CB);
      chk("bp_valid", 128'(out_valid), 128'(1));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      step();
    end
    out_ready = 1;
    step();
    chk("bp_release_ready", 128'(in_ready), 128'(1));
    chk("bp_release_valid", 128'(out_valid), 128'(0));
    send(PB, KB, CB);
    for (int i = 0; i < 9; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_key = {$urandom, $urandom, $urandom, $urandom};
      chk("churn_in_ready", 128'(in_ready), 128'(0));
      step();
    end
    in_valid = 0;
    wait_out(n);
    step();
    send(PC, KC, CC);
    in_valid = 0;
    n = 0;
    while (round != 4'd5 && n < 20) begin
      step();
      n++;
    end
    chk("reach_round5", 128'(round), 128'(5));
    rst = 0;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_round", 128'(round), 128'(0));
    chk("mid_rst_data", out_data, 128'(0));
    sb.delete();
    step();
    rst = 1;
    chk("post_rst_ready", 128'(in_ready), 128'(1));
    send(PC, KC, CC);
    in_valid = 0;
    wait_out(n);
    chk("latency_c", 128'(n), 128'(10));
    step();
    send(PB, KB, CB);
    send(PC, KC, CC);
    chk("b2b_spacing", 128'(t_acc - t_prev), 128'(12));
    in_valid = 0;
    wait_out(n);
    step();
    chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/aes_cipher_seq.md
# aes_cipher_seq

Iterative AES-128 encryption sequencer. Accepts one plaintext block and one cipher key per handshake and runs all cipher rounds over a single shared round datapath, one round per clock. The datapath is subBytes -> shiftRows -> mixColumns -> addRoundKey, with round keys expanded on the fly. It sits between the block-level stream interface and the AES round primitives in the Cipher design, replacing the fully unrolled cipher where area matters.

## Interface
- `ROUNDS`, default 10: number of cipher rounds. Only 10 (AES-128) is supported; round-counter width is derived from it.

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  plaintext/key offered
- `in_ready`  out  1  sequencer can accept a block
- `in_data`  in  128 (`t_opaque_AESState`)  plaintext; `state[c][r]`, byte `state[0][0]` is bits 127:120
- `in_key`  in  128 (`t_opaque_AESKey`)  cipher key, same byte order
- `out_valid`  out  1  ciphertext available
- `out_ready`  in  1  consumer accepts ciphertext
- `out_data`  out  128 (`t_opaque_AESState`)  ciphertext
- `busy`  out  1  high while in RUN
- `round`  out  4  current round index, for debug

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - RUN: rounds 1..ROUNDS.
  - DONE: `out_valid`=1.
- On IDLE with `in_valid`&`in_ready`:
  - `state_reg` <= `in_data` XOR `in_key` (initial AddRoundKey).
  - `key_reg` <= `in_key`; `rcon_reg` <= 8'h01; `round` <= 1.
  - Go to RUN.
- Each RUN cycle:
  - `nk` = keyStep(`key_reg`, `rcon_reg`).
  - If `round` < ROUNDS: `state_reg` <= mixColumns(shiftRows(subBytes(`state_reg`))) XOR `nk`.
  - If `round` == ROUNDS: mixColumns is bypassed, so `state_reg` <= shiftRows(subBytes(`state_reg`)) XOR `nk`.
  - `key_reg` <= `nk`.
  - `rcon_reg` <= xtime(`rcon_reg`), where xtime = shift left 1 and XOR 8'h1b if the MSB was set. Sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - `round` += 1. On `round` == ROUNDS, go to DONE instead of incrementing.
- DONE:
  - `out_data` = `state_reg`, held stable while `out_valid`=1 and `out_ready`=0.
  - On `out_ready`=1, go to IDLE.
- `in_ready` is 0 in RUN and DONE. Input changes during RUN are ignored; no pipelining of a second block.
- keyStep (standard FIPS-197 expansion of 4 words):
  - `t` = SubWord(RotWord(w3)) XOR {rcon, 0, 0, 0}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
- Reset (async assert, any state, including mid-RUN):
  - FSM to IDLE; `round`=0; `busy`=0; `out_valid`=0; `in_ready`=1 after reset deassertion.
  - `state_reg`, `key_reg`, and therefore `out_data`, reset to 0.
  - `rcon_reg` resets to 8'h01.
  - An in-flight block is discarded silently.

## Timing
- Acceptance edge = edge E0. RUN occupies edges E1..E10. `out_valid` rises after E10, so latency from accept to `out_valid` is 10 cycles after the accept edge (11 edges total including accept).
- Minimum throughput: one block per 12 cycles (accept, 10 rounds, 1 DONE cycle with `out_ready`=1).
- `in_ready` rises the cycle after the DONE handshake; there is no same-cycle IDLE re-accept from DONE.
- All outputs are registered or decoded from FSM state only; no combinational in-to-out paths.
- `out_valid` never drops without a handshake. `out_data` must not change while `out_valid`=1.

## Structure
- Shared package (Cipher_defs) holds:
  - `t_opaque_AESState`, `t_opaque_AESKey`, `t_opaque_AESWord`, and the S-box constant array.
  - An FSM state enum `t_aes_seq_state` {IDLE, RUN, DONE}.
  - Constant `AES128_ROUNDS`=10.
- Round primitives are instantiated, not reimplemented: the existing subBytes, shiftRows, mixColumns and addRoundKey modules.
- One new sub-module is natural: `aes_key_step` (inputs: key, rcon; output: next round key; combinational).
- Sequencer RTL: FSM, counters, rcon register and muxes, roughly 150-250 lines.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, `out_ready`=1 -> ct 3925841d02dc09fbdc118597196a0b32, `out_valid` 10 cycles after accept.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a. Also check `round` steps 1..10 on consecutive cycles.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid` -> `out_data` stable, `in_ready`=0 throughout. Release -> one handshake, then `in_ready`=1 next cycle.
- Input churn: `in_valid`=1 held with changing data during RUN -> result equals the App. B ct (first accepted block only); next block accepted only from IDLE.
- Reset mid-op: assert `rst`=0 at round 5 -> immediately `out_valid`=0, `busy`=0, `round`=0. After release, App. C.1 vector -> correct ct.
- Back-to-back: App. B then App. C.1 with `in_valid` held high -> both cts correct, accepts spaced exactly 12 cycles apart.
